// File: rtl/trace_capture_if.sv
// Read-side stream of the trace capture FIFO.
//   rd_valid : head entry is present on rd_data
//   rd_ready : consumer takes the head entry this cycle
//   rd_data  : head entry packed as {command[22:0], bus[15:0]}
// The master modport is the FIFO side; the slave modport is the consumer.
interface trace_capture_if;
  localparam int unsigned DATA_W = 39;

  logic              rd_valid;
  logic              rd_ready;
  logic [DATA_W-1:0] rd_data;

  modport master (output rd_valid, output rd_data, input rd_ready);
  modport slave  (input rd_valid, input rd_data, output rd_ready);
endinterface

// File: rtl/trace_capture.sv
// Captures {command, bus} snapshots of an observed processor into a show-ahead
// FIFO. A start pulse arms capture: the first armed cycle always records one
// entry, and later cycles record an entry only when command changes. A stop
// pulse disarms capture. Pushes into a full FIFO with no same-cycle pop are
// dropped and counted.
// Ports:
//   clk, rst         : single clock, synchronous active-high reset
//   start, stop      : single-cycle arm / disarm pulses
//   command, bus     : observed processor control word and data bus
//   rd               : show-ahead read stream (trace_capture_if.master)
//   level            : FIFO occupancy
//   full, empty      : FIFO status flags
//   overflow_cnt     : dropped captures, saturating at 255
//   armed            : capture is active (FIRST or RUN)
module trace_capture #(
  parameter int unsigned DEPTH = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    stop,
  input  logic [22:0]             command,
  input  logic [15:0]             bus,
  trace_capture_if.master         rd,
  output logic [$clog2(DEPTH):0]  level,
  output logic                    full,
  output logic                    empty,
  output logic [7:0]              overflow_cnt,
  output logic                    armed
);

  localparam int unsigned CMD_W = 23;
  localparam int unsigned BUS_W = 16;
  localparam int unsigned ENT_W = CMD_W + BUS_W;
  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned LW    = AW + 1;
  localparam int unsigned OVF_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FIRST = 2'd1,
    RUN   = 2'd2
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic               push_req;
  logic [CMD_W-1:0]   prev_cmd;

  logic [ENT_W-1:0]   mem [DEPTH];
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic               pop;
  logic               push_ok;
  logic               drop;

  // State register and last-seen command (held while idle).
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      prev_cmd <= '0;
    end else begin
      state <= state_nxt;
      if (state != IDLE) begin
        prev_cmd <= command;
      end
    end
  end

  // Next state and push request; stop always wins while armed.
  always_comb begin
    state_nxt = state;
    push_req  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = FIRST;
        end
      end
      FIRST: begin
        if (stop) begin
          state_nxt = IDLE;
        end else begin
          push_req  = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (stop) begin
          state_nxt = IDLE;
        end else begin
          push_req = (command != prev_cmd);
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign armed = (state != IDLE);

  // A pop frees a slot in the same cycle, so a full FIFO still accepts a push
  // when the head is being consumed (the write lands in the slot just read).
  assign pop     = !empty && rd.rd_ready;
  assign push_ok = push_req && (!full || pop);
  assign drop    = push_req && full && !pop;

  // Entry storage; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (!rst && push_ok) begin
      mem[wr_ptr] <= {command, bus};
    end
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      level        <= '0;
      overflow_cnt <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (push_ok && !pop) begin
        level <= level + LW'(1);
      end else if (!push_ok && pop) begin
        level <= level - LW'(1);
      end
      if (drop && (overflow_cnt != {OVF_W{1'b1}})) begin
        overflow_cnt <= overflow_cnt + OVF_W'(1);
      end
    end
  end

  assign full        = (level == LW'(DEPTH));
  assign empty       = (level == '0);
  assign rd.rd_valid = !empty;
  assign rd.rd_data  = mem[rd_ptr];

endmodule

// File: tb/tb_trace_capture.sv
// Directed bench for trace_capture with a scoreboard: stimulus pushes the
// hand-computed entries into a queue, and a monitor compares every popped
// rd_data against the queue head.
module tb_trace_capture;

  localparam int unsigned DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        stop;
  logic [22:0] command;
  logic [15:0] bus;
  logic [3:0]  level;
  logic        full;
  logic        empty;
  logic [7:0]  overflow_cnt;
  logic        armed;

  trace_capture_if rd_if();

  trace_capture #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .stop         (stop),
    .command      (command),
    .bus          (bus),
    .rd           (rd_if),
    .level        (level),
    .full         (full),
    .empty        (empty),
    .overflow_cnt (overflow_cnt),
    .armed        (armed)
  );

  always #5 clk = ~clk;

  logic [38:0] expq [$];
  int          checks   = 0;
  int          failures = 0;
  logic [22:0] seq_cmd [5] = '{23'd1, 23'd1, 23'd2, 23'd2, 23'd3};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_push(input logic [22:0] c, input logic [15:0] b);
    expq.push_back({c, b});
  endtask

  // Drain everything currently stored, bounded so a stuck FIFO cannot hang.
  task automatic drain(input string name);
    rd_if.rd_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (!rd_if.rd_valid) break;
      cyc();
    end
    rd_if.rd_ready = 1'b0;
    chk(name, 64'(empty), 64'd1);
  endtask

  // Monitor: every accepted head entry must match the scoreboard head.
  always @(negedge clk) begin
    if (!rst && rd_if.rd_valid && rd_if.rd_ready) begin
      if (expq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_entry actual=%h expected=none t=%0t", rd_if.rd_data, $time);
      end else begin
        chk("drain_order", 64'(rd_if.rd_data), 64'(expq.pop_front()));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout t=%0t", $time);
    $fatal(1);
  end

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0;
    command = '0; bus = '0; rd_if.rd_ready = 1'b0;
    cyc(); cyc();
    rst = 1'b0;
    cyc();
    chk("rst_level", 64'(level), 64'd0);
    chk("rst_empty", 64'(empty), 64'd1);
    chk("rst_full", 64'(full), 64'd0);
    chk("rst_rd_valid", 64'(rd_if.rd_valid), 64'd0);
    chk("rst_armed", 64'(armed), 64'd0);
    chk("rst_overflow", 64'(overflow_cnt), 64'd0);

    // Start with constant command: exactly one FIRST entry.
    command = 23'h000001; bus = 16'hAAAA; start = 1'b1;
    cyc();
    start = 1'b0;
    chk("first_armed", 64'(armed), 64'd1);
    chk("first_level_before", 64'(level), 64'd0);
    exp_push(23'h000001, 16'hAAAA);
    cyc();
    chk("first_level", 64'(level), 64'd1);
    chk("first_rd_valid", 64'(rd_if.rd_valid), 64'd1);
    chk("first_rd_data", 64'(rd_if.rd_data), 64'h00_0001_AAAA);
    cyc();
    chk("const_cmd_no_push", 64'(level), 64'd1);

    // Command sequence 1,1,2,2,3: pushes only on the changes to 2 and 3.
    for (int i = 0; i < 5; i++) begin
      command = seq_cmd[i];
      bus     = 16'h1000 + 16'(i);
      cyc();
    end
    exp_push(23'd2, 16'h1002);
    exp_push(23'd3, 16'h1004);
    chk("change_level", 64'(level), 64'd3);
    drain("change_drain_empty");

    // Ten distinct commands into an empty FIFO: last two dropped.
    for (int i = 0; i < 10; i++) begin
      command = 23'h100 + 23'(i);
      bus     = 16'hB000 + 16'(i);
      if (i < 8) exp_push(23'h100 + 23'(i), 16'hB000 + 16'(i));
      cyc();
    end
    chk("ovf_full", 64'(full), 64'd1);
    chk("ovf_level", 64'(level), 64'd8);
    chk("ovf_count", 64'(overflow_cnt), 64'd2);
    chk("ovf_not_empty", 64'(empty), 64'd0);

    // Full with simultaneous pop and push: push accepted, lands last.
    command = 23'h200; bus = 16'hC200; rd_if.rd_ready = 1'b1;
    exp_push(23'h200, 16'hC200);
    cyc();
    rd_if.rd_ready = 1'b0;
    chk("full_pp_level", 64'(level), 64'd8);
    chk("full_pp_full", 64'(full), 64'd1);
    chk("full_pp_overflow", 64'(overflow_cnt), 64'd2);
    drain("full_pp_drain_empty");

    // Stop together with a command change: no push, disarmed.
    command = 23'h300; bus = 16'h3333; stop = 1'b1;
    cyc();
    stop = 1'b0;
    chk("stop_armed", 64'(armed), 64'd0);
    cyc();
    chk("stop_no_push", 64'(level), 64'd0);
    stop = 1'b1; command = 23'h301;
    cyc();
    stop = 1'b0;
    chk("idle_stop_armed", 64'(armed), 64'd0);
    chk("idle_no_push", 64'(level), 64'd0);

    // Restart with command equal to the last seen one: FIRST still pushes.
    command = 23'h300; bus = 16'hD300; start = 1'b1;
    cyc();
    start = 1'b0;
    chk("restart_armed", 64'(armed), 64'd1);
    exp_push(23'h300, 16'hD300);
    cyc();
    chk("restart_level", 64'(level), 64'd1);
    chk("restart_rd_data", 64'(rd_if.rd_data), 64'h00_0300_D300);

    // Fill to five entries, then reset mid-capture (start asserted too).
    for (int i = 0; i < 4; i++) begin
      command = 23'h400 + 23'(i);
      bus     = 16'hE400 + 16'(i);
      exp_push(23'h400 + 23'(i), 16'hE400 + 16'(i));
      cyc();
    end
    chk("pre_rst_level", 64'(level), 64'd5);
    chk("pre_rst_armed", 64'(armed), 64'd1);
    rst = 1'b1; start = 1'b1;
    cyc();
    rst = 1'b0; start = 1'b0;
    expq.delete();
    chk("mid_rst_level", 64'(level), 64'd0);
    chk("mid_rst_empty", 64'(empty), 64'd1);
    chk("mid_rst_full", 64'(full), 64'd0);
    chk("mid_rst_armed", 64'(armed), 64'd0);
    chk("mid_rst_overflow", 64'(overflow_cnt), 64'd0);
    chk("mid_rst_rd_valid", 64'(rd_if.rd_valid), 64'd0);
    cyc();
    chk("post_rst_armed", 64'(armed), 64'd0);

    // rd_ready while empty has no effect.
    rd_if.rd_ready = 1'b1;
    cyc();
    rd_if.rd_ready = 1'b0;
    chk("empty_pop_level", 64'(level), 64'd0);
    chk("empty_pop_empty", 64'(empty), 64'd1);

    chk("scoreboard_leftover", 64'(expq.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
